sm_add_arbiter: RTL and testbench

- Shares one sign-magnitude adder datapath between NUM_REQ requesters, using round-robin arbitration.
- Each requester presents an operand pair (A, B) in sign-magnitude form with a valid/ready handshake.
- The granted pair is summed and the sign-magnitude result is registered.
- The result is returned on a single output channel, tagged with the requester id.
- Sits between the requesting engines and downstream result consumers.

---
 rtl/sm_add_pkg.sv | 16 +
 rtl/sm_add_arbiter_rr_pick.sv | 23 ++
 rtl/sm_add_arbiter.sv | 76 +++++++
 tb/tb_sm_add_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_add_pkg.sv
// sm_add_pkg: shared types and default sizes for the sign-magnitude adder arbiter
package sm_add_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int MAG_W_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int ID_W = $clog2(NUM_REQ_DEF);
  typedef struct packed {
    logic sign;
    logic [MAG_W_DEF-1:0] mag;
  } sm_operand_t;
  typedef struct packed {
    logic sign;
    logic [MAG_W_DEF:0] mag;
  } sm_result_t;
  typedef enum logic {IDLE, FULL} arb_state_t;
endpackage

// File: rtl/sm_add_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts one past ptr and wraps
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  // scan farthest-to-nearest so the nearest valid requester after ptr wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/sm_add_arbiter.sv
// sm_add_arbiter: round-robin shared sign-magnitude adder with a one-deep result register
module sm_add_arbiter
  import sm_add_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int MAG_W = MAG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*MAG_W-1:0]   req_a_mag,
  input  logic [NUM_REQ-1:0]         req_a_sign,
  input  logic [NUM_REQ*MAG_W-1:0]   req_b_mag,
  input  logic [NUM_REQ-1:0]         req_b_sign,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [MAG_W:0]             res_mag,
  output logic                       res_sign,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic [CNT_W-1:0]           ops_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = MAG_W + 2;
  arb_state_t state;
  logic [IW-1:0] rr_ptr, pick_idx;
  logic [NUM_REQ-1:0] grant;
  logic accept, xfer;
  logic [MAG_W-1:0] a_mag, b_mag;
  logic a_sign, b_sign;
  logic signed [SW-1:0] a_val, b_val, sum, abs_sum;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(pick_idx)
  );
  assign accept = (state == IDLE) || res_ready;
  assign xfer = accept && |req_valid && !rst;
  assign req_ready = xfer ? grant : '0;
  assign res_valid = (state == FULL);
  // negating a zero magnitude yields zero, so -0 operands and zero sums come out positive
  always_comb begin
    a_mag = req_a_mag[pick_idx*MAG_W +: MAG_W];
    b_mag = req_b_mag[pick_idx*MAG_W +: MAG_W];
    a_sign = req_a_sign[pick_idx];
    b_sign = req_b_sign[pick_idx];
    a_val = a_sign ? -$signed({2'b00, a_mag}) : $signed({2'b00, a_mag});
    b_val = b_sign ? -$signed({2'b00, b_mag}) : $signed({2'b00, b_mag});
    sum = a_val + b_val;
    abs_sum = sum[SW-1] ? -sum : sum;
  end
  // state, result registers, round-robin pointer and saturating completion counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      res_mag <= '0;
      res_sign <= 1'b0;
      res_id <= '0;
      rr_ptr <= IW'(NUM_REQ - 1);
      ops_cnt <= '0;
    end else begin
      if (res_valid && res_ready && ops_cnt != '1) ops_cnt <= ops_cnt + 1'b1;
      if (xfer) begin
        state <= FULL;
        res_sign <= sum[SW-1];
        res_mag <= abs_sum[MAG_W:0];
        res_id <= pick_idx;
        rr_ptr <= pick_idx;
      end else if (res_ready) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_sm_add_arbiter.sv
// tb_sm_add_arbiter: randomized self-checking bench against a behavioural arbiter/adder model
module tb_sm_add_arbiter;
  localparam int N = 4;
  localparam int MW = 4;
  localparam int CW = 4;
  localparam int IW = 2;
  localparam int CMAX = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*MW-1:0] req_a_mag = '0;
  logic [N-1:0] req_a_sign = '0;
  logic [N*MW-1:0] req_b_mag = '0;
  logic [N-1:0] req_b_sign = '0;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [MW:0] res_mag;
  logic res_sign;
  logic [IW-1:0] res_id;
  logic [CW-1:0] ops_cnt;
  int m_ptr, m_cnt, m_id, m_mag;
  bit m_full, m_sign;
  logic [N-1:0] exp_ready, obs_ready;
  logic [MW:0] e_mag;
  logic [IW-1:0] e_id;
  int n_cmp = 0;
  int n_bad = 0;

  sm_add_arbiter #(.NUM_REQ(N), .MAG_W(MW), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a_mag(req_a_mag),
    .req_a_sign(req_a_sign),
    .req_b_mag(req_b_mag),
    .req_b_sign(req_b_sign),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_mag(res_mag),
    .res_sign(res_sign),
    .res_id(res_id),
    .ops_cnt(ops_cnt)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int sm_val(input logic s, input int m);
    return s ? -m : m;
  endfunction

  task automatic model_reset();
    m_ptr = N - 1;
    m_cnt = 0;
    m_full = 0;
    m_sign = 0;
    m_mag = 0;
    m_id = 0;
  endtask

  task automatic set_op(input int i, input logic as, input int am, input logic bs, input int bm);
    req_a_sign[i] = as;
    req_a_mag[i*MW +: MW] = MW'(am);
    req_b_sign[i] = bs;
    req_b_mag[i*MW +: MW] = MW'(bm);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++)
      set_op(i, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic tick();
    int g, s;
    bit acc;
    acc = !m_full || res_ready;
    g = pick(req_valid, m_ptr);
    exp_ready = (acc && g >= 0) ? (N'(1) << g) : '0;
    @(negedge clk);
    obs_ready = req_ready;
    @(posedge clk);
    if (m_full && res_ready) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
    if (acc && g >= 0) begin
      s = sm_val(req_a_sign[g], int'(req_a_mag[g*MW +: MW])) + sm_val(req_b_sign[g], int'(req_b_mag[g*MW +: MW]));
      m_full = 1;
      m_sign = s < 0;
      m_mag = s < 0 ? -s : s;
      m_id = g;
      m_ptr = g;
    end else if (res_ready) begin
      m_full = 0;
    end
    e_mag = m_mag[MW:0];
    e_id = m_id[IW-1:0];
    #1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    #12;
    n_cmp += 6;
    if (req_ready !== '0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    if (res_mag !== '0) begin n_bad++; $display("FAIL reset_mag got=%0d exp=0", res_mag); end
    if (res_sign !== 1'b0) begin n_bad++; $display("FAIL reset_sign got=%b exp=0", res_sign); end
    if (res_id !== '0) begin n_bad++; $display("FAIL reset_id got=%0d exp=0", res_id); end
    if (ops_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", ops_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;
    model_reset();
  endtask

  task automatic test_single();
    set_op(2, 1'b0, 5, 1'b1, 3);
    req_valid = 4'b0100;
    res_ready = 1'b1;
    tick();
    n_cmp += 6;
    if (obs_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got=%b exp=0100", obs_ready); end
    if (res_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", res_valid); end
    if (res_sign !== 1'b0) begin n_bad++; $display("FAIL single_sign got=%b exp=0", res_sign); end
    if (res_mag !== 5'd2) begin n_bad++; $display("FAIL single_mag got=%0d exp=2", res_mag); end
    if (res_id !== 2'd2) begin n_bad++; $display("FAIL single_id got=%0d exp=2", res_id); end
    if (ops_cnt !== 4'd0) begin n_bad++; $display("FAIL single_cnt0 got=%0d exp=0", ops_cnt); end
    req_valid = '0;
    tick();
    n_cmp += 2;
    if (ops_cnt !== 4'd1) begin n_bad++; $display("FAIL single_cnt1 got=%0d exp=1", ops_cnt); end
    if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got=%b exp=0", res_valid); end
  endtask

  task automatic test_round_robin();
    reset_dut();
    req_valid = '1;
    res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rand_ops();
      tick();
      n_cmp += 5;
      if (obs_ready !== (N'(1) << (c % N))) begin n_bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, obs_ready, N'(1) << (c % N)); end
      if (res_id !== IW'(c % N)) begin n_bad++; $display("FAIL rr_id c=%0d got=%0d exp=%0d", c, res_id, c % N); end
      if (res_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid c=%0d got=%b exp=1", c, res_valid); end
      if ({res_sign, res_mag} !== {m_sign, e_mag}) begin n_bad++; $display("FAIL rr_sum c=%0d got=%b/%0d exp=%b/%0d", c, res_sign, res_mag, m_sign, e_mag); end
      if (ops_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL rr_cnt c=%0d got=%0d exp=%0d", c, ops_cnt, m_cnt); end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_extremes();
    req_valid = 4'b0001;
    res_ready = 1'b1;
    set_op(0, 1'b1, 15, 1'b1, 15);
    tick();
    n_cmp += 2;
    if ({res_sign, res_mag} !== {1'b1, 5'd30}) begin n_bad++; $display("FAIL ext_neg got=%b/%0d exp=1/30", res_sign, res_mag); end
    if (res_id !== 2'd0) begin n_bad++; $display("FAIL ext_id got=%0d exp=0", res_id); end
    set_op(0, 1'b0, 15, 1'b1, 15);
    tick();
    n_cmp += 2;
    if ({res_sign, res_mag} !== {1'b0, 5'd0}) begin n_bad++; $display("FAIL ext_zero got=%b/%0d exp=0/0", res_sign, res_mag); end
    if (obs_ready !== 4'b0001) begin n_bad++; $display("FAIL ext_b2b got=%b exp=0001", obs_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [MW+IW+1:0] held;
    req_valid = 4'b0010;
    res_ready = 1'b1;
    rand_ops();
    tick();
    held = {res_sign, res_mag, res_id};
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_ops();
      tick();
      n_cmp += 3;
      if (obs_ready !== '0) begin n_bad++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, obs_ready); end
      if (res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, res_valid); end
      if ({res_sign, res_mag, res_id} !== held) begin n_bad++; $display("FAIL bp_hold c=%0d got=%h exp=%h", c, {res_sign, res_mag, res_id}, held); end
    end
    res_ready = 1'b1;
    tick();
    n_cmp += 3;
    if (obs_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_release got=%b exp=0010", obs_ready); end
    if ({res_sign, res_mag, res_id} !== {m_sign, e_mag, 2'd1}) begin n_bad++; $display("FAIL bp_new got=%b/%0d/%0d exp=%b/%0d/1", res_sign, res_mag, res_id, m_sign, e_mag); end
    if (ops_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL bp_cnt got=%0d exp=%0d", ops_cnt, m_cnt); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_neg_zero();
    req_valid = 4'b0001;
    res_ready = 1'b1;
    set_op(0, 1'b1, 0, 1'b0, 0);
    tick();
    n_cmp++;
    if ({res_sign, res_mag} !== 6'd0) begin n_bad++; $display("FAIL nz_a got=%b/%0d exp=0/0", res_sign, res_mag); end
    set_op(0, 1'b1, 0, 1'b1, 0);
    tick();
    n_cmp++;
    if ({res_sign, res_mag} !== 6'd0) begin n_bad++; $display("FAIL nz_ab got=%b/%0d exp=0/0", res_sign, res_mag); end
    set_op(0, 1'b1, 7, 1'b0, 7);
    tick();
    n_cmp++;
    if ({res_sign, res_mag} !== 6'd0) begin n_bad++; $display("FAIL nz_cancel got=%b/%0d exp=0/0", res_sign, res_mag); end
    set_op(0, 1'b1, 0, 1'b1, 9);
    tick();
    n_cmp++;
    if ({res_sign, res_mag} !== {1'b1, 5'd9}) begin n_bad++; $display("FAIL nz_mixed got=%b/%0d exp=1/9", res_sign, res_mag); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      res_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      tick();
      n_cmp += 3;
      if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
      if (res_valid !== m_full) begin n_bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, res_valid, m_full); end
      if (ops_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, ops_cnt, m_cnt); end
      if (m_full) begin
        n_cmp++;
        if ({res_sign, res_mag, res_id} !== {m_sign, e_mag, e_id}) begin n_bad++; $display("FAIL rnd_res c=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", c, res_sign, res_mag, res_id, m_sign, e_mag, e_id); end
      end
    end
    n_cmp++;
    if (ops_cnt !== 4'd15) begin n_bad++; $display("FAIL rnd_sat got=%0d exp=15", ops_cnt); end
  endtask

  task automatic test_reset_mid();
    req_valid = '1;
    res_ready = 1'b0;
    rand_ops();
    tick();
    n_cmp++;
    if (res_valid !== 1'b1) begin n_bad++; $display("FAIL rm_full got=%b exp=1", res_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp += 3;
    if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid got=%b exp=0", res_valid); end
    if (ops_cnt !== '0) begin n_bad++; $display("FAIL rm_cnt got=%0d exp=0", ops_cnt); end
    if (req_ready !== '0) begin n_bad++; $display("FAIL rm_ready got=%b exp=0", req_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    req_valid = 4'b1010;
    res_ready = 1'b1;
    tick();
    n_cmp += 2;
    if (obs_ready !== 4'b0010) begin n_bad++; $display("FAIL rm_first got=%b exp=0010", obs_ready); end
    if (res_id !== 2'd1) begin n_bad++; $display("FAIL rm_id got=%0d exp=1", res_id); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_extremes();
    test_backpressure();
    test_neg_zero();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
